// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_pkg
// Purpose  : Shared state encoding, timing defaults and widths for sram_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_ACK     = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam int c_RD_CYCLES_DEFAULT   = 2;
    localparam int c_WR_CYCLES_DEFAULT   = 2;
    localparam int c_TURN_CYCLES_DEFAULT = 1;

    localparam int c_LANES  = 4;
    localparam int c_LANE_W = 2;
    localparam int c_CS_W   = 4;
    localparam int c_CNT_W  = 4;

    // Lowest selected lane; lanes are always visited in ascending order.
    function automatic logic [c_LANE_W-1:0] first_lane(input logic [c_LANES-1:0] mask);
        if (mask[0])      first_lane = 2'd0;
        else if (mask[1]) first_lane = 2'd1;
        else if (mask[2]) first_lane = 2'd2;
        else              first_lane = 2'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_timer
// Purpose  : 4-bit loadable down-counter timing ACCESS and RECOVER phases.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl_timer
    import sram_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_load,
    input  logic [c_CNT_W-1:0] i_load_val,
    output logic               o_done
);

    logic [c_CNT_W-1:0] r_count;

    // Loading N-1 makes a phase last N cycles, ending on the cycle done is seen.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Wishbone slave to four 2Mx8 asynchronous SRAMs, one byte per lane.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int SRAM_RD_CYCLES   = c_RD_CYCLES_DEFAULT,
    parameter int SRAM_WR_CYCLES   = c_WR_CYCLES_DEFAULT,
    parameter int SRAM_TURN_CYCLES = c_TURN_CYCLES_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [31:0]       i_wb_adr,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic [31:0]       i_wb_dat,
    output logic [31:0]       o_wb_dat,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic [c_CS_W-1:0] o_sram_cs_n,
    output logic              o_sram_read_n,
    output logic              o_sram_write_n,
    output logic [20:0]       o_sram_addr,
    inout  wire  [7:0]        io_sram_data
);

    localparam logic [c_CNT_W-1:0] c_RD_LOAD   = c_CNT_W'(SRAM_RD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD   = c_CNT_W'(SRAM_WR_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TURN_LOAD = c_CNT_W'(SRAM_TURN_CYCLES - 1);

    state_t                r_state;
    logic [18:0]           r_word;
    logic [c_LANES-1:0]    r_pending;
    logic [c_LANE_W-1:0]   r_lane;
    logic                  r_we;
    logic                  r_abort;
    logic [31:0]           r_wdat;
    logic [31:0]           r_rdbuf;
    logic                  r_drive;
    logic [7:0]            r_dout;

    logic                  w_tmr_load;
    logic [c_CNT_W-1:0]    w_tmr_val;
    logic                  w_tmr_done;
    logic [c_LANE_W-1:0]   w_first_sel;
    logic [c_LANE_W-1:0]   w_next_lane;
    logic                  w_unused;

    assign w_first_sel = first_lane(i_wb_sel);
    assign w_next_lane = first_lane(r_pending);
    assign w_unused    = ^i_wb_adr[1:0];

    // Gating with read_n guarantees the bus is released whenever the SRAM may drive it.
    assign io_sram_data = (r_drive && o_sram_read_n) ? r_dout : 8'hzz;

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_TURN_LOAD;
        case (r_state)
            ST_SETUP: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = r_we ? c_WR_LOAD : c_RD_LOAD;
            end
            ST_ACCESS: begin
                w_tmr_load = w_tmr_done;
            end
            default: ;
        endcase
    end

    sram_ctrl_timer u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_word         <= '0;
            r_pending      <= '0;
            r_lane         <= '0;
            r_we           <= 1'b0;
            r_abort        <= 1'b0;
            r_wdat         <= '0;
            r_rdbuf        <= '0;
            r_drive        <= 1'b0;
            r_dout         <= '0;
            o_wb_dat       <= '0;
            o_wb_ack       <= 1'b0;
            o_wb_err       <= 1'b0;
            o_sram_cs_n    <= '1;
            o_sram_read_n  <= 1'b1;
            o_sram_write_n <= 1'b1;
            o_sram_addr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        r_we    <= i_wb_we;
                        r_wdat  <= i_wb_dat;
                        r_abort <= 1'b0;
                        r_rdbuf <= '0;
                        if (i_wb_adr[31:23] != '0) begin
                            r_state  <= ST_ERR;
                            o_wb_err <= 1'b1;
                        end else if (i_wb_sel == '0) begin
                            r_state  <= ST_ACK;
                            o_wb_ack <= 1'b1;
                            if (!i_wb_we) o_wb_dat <= '0;
                        end else begin
                            r_state     <= ST_SETUP;
                            r_word      <= i_wb_adr[20:2];
                            r_lane      <= w_first_sel;
                            r_pending   <= i_wb_sel & ~(4'b0001 << w_first_sel);
                            o_sram_cs_n <= ~(4'b0001 << i_wb_adr[22:21]);
                            o_sram_addr <= {i_wb_adr[20:2], w_first_sel};
                            r_drive     <= i_wb_we;
                            r_dout      <= i_wb_dat[{w_first_sel, 3'b000} +: 8];
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    if (r_we) o_sram_write_n <= 1'b0;
                    else      o_sram_read_n  <= 1'b0;
                end
                ST_ACCESS: begin
                    if (w_tmr_done) begin
                        r_state        <= ST_RECOVER;
                        o_sram_read_n  <= 1'b1;
                        o_sram_write_n <= 1'b1;
                        if (!r_we) r_rdbuf[{r_lane, 3'b000} +: 8] <= io_sram_data;
                    end
                end
                ST_RECOVER: begin
                    if (w_tmr_done) begin
                        if (r_abort || !i_wb_cyc) begin
                            r_state     <= ST_IDLE;
                            o_sram_cs_n <= '1;
                            r_drive     <= 1'b0;
                        end else if (r_pending == '0) begin
                            r_state     <= ST_ACK;
                            o_wb_ack    <= 1'b1;
                            o_sram_cs_n <= '1;
                            r_drive     <= 1'b0;
                            if (!r_we) o_wb_dat <= r_rdbuf;
                        end else begin
                            r_state     <= ST_SETUP;
                            r_lane      <= w_next_lane;
                            r_pending   <= r_pending & ~(4'b0001 << w_next_lane);
                            o_sram_addr <= {r_word, w_next_lane};
                            r_dout      <= r_wdat[{w_next_lane, 3'b000} +: 8];
                        end
                    end
                end
                ST_ACK, ST_ERR: begin
                    r_state  <= ST_IDLE;
                    o_wb_ack <= 1'b0;
                    o_wb_err <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
            // A dropped cycle is remembered so the lane in flight still completes cleanly.
            if (r_state != ST_IDLE && !i_wb_cyc) r_abort <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : Directed bench for sram_ctrl with a cycle-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    localparam int c_WR   = 2;
    localparam int c_TURN = 1;

    typedef struct {
        logic        chk_cs;
        logic [3:0]  cs_n;
        logic        rd_n;
        logic        wr_n;
        logic        ack;
        logic        err;
        logic        chk_addr;
        logic [20:0] addr;
        logic        chk_dat;
        logic [31:0] dat;
        logic        chk_bus;
        logic [7:0]  bus;
    } exp_t;

    logic        tb_sram_clk = 1'b0;
    logic        reset_n;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic [1:0]  wb_cyc;
    logic [1:0]  wb_stb;

    logic [31:0] wb_dat_o [2];
    logic        ack      [2];
    logic        err      [2];
    logic [3:0]  cs_n     [2];
    logic        rd_n     [2];
    logic        wr_n     [2];
    logic [20:0] addr     [2];
    logic [7:0]  bus_obs  [2];
    logic [1:0]  dev_of   [2];
    logic        probe_en [2];

    logic [7:0]  sram_mem [2][4][64];
    logic [7:0]  ref_mem  [2][4][64];

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_errors = 0;
    int wr_low_cnt [2];
    int rd_low_cnt [2];
    logic cmp_en = 1'b0;

    always #5 tb_sram_clk = ~tb_sram_clk;

    function automatic int rd_cycles(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        wire  [7:0] sram_bus;
        logic [1:0] dev;

        always_comb begin
            dev = 2'd0;
            for (int i = 0; i < 4; i++) if (!cs_n[k][i]) dev = 2'(i);
        end

        // SRAM model drives only while output-enabled; the probe drives zeros to detect a stray driver.
        assign sram_bus   = (!rd_n[k] || probe_en[k]) ?
                            (probe_en[k] ? 8'h00 : sram_mem[k][dev][addr[k][5:0]]) : 8'hzz;
        assign bus_obs[k] = sram_bus;
        assign dev_of[k]  = dev;

        sram_ctrl #(
            .SRAM_RD_CYCLES   (k == 0 ? 2 : 3),
            .SRAM_WR_CYCLES   (c_WR),
            .SRAM_TURN_CYCLES (c_TURN)
        ) u_dut (
            .i_clk          (tb_sram_clk),
            .i_reset_n      (reset_n),
            .i_wb_adr       (wb_adr),
            .i_wb_sel       (wb_sel),
            .i_wb_we        (wb_we),
            .i_wb_cyc       (wb_cyc[k]),
            .i_wb_stb       (wb_stb[k]),
            .i_wb_dat       (wb_dat),
            .o_wb_dat       (wb_dat_o[k]),
            .o_wb_ack       (ack[k]),
            .o_wb_err       (err[k]),
            .o_sram_cs_n    (cs_n[k]),
            .o_sram_read_n  (rd_n[k]),
            .o_sram_write_n (wr_n[k]),
            .o_sram_addr    (addr[k]),
            .io_sram_data   (sram_bus)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp_v);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.chk_cs = 1'b1; e.cs_n = 4'hF; e.rd_n = 1'b1; e.wr_n = 1'b1;
        e.ack = 1'b0; e.err = 1'b0;
        e.chk_addr = 1'b0; e.addr = '0;
        e.chk_dat = 1'b0; e.dat = '0;
        e.chk_bus = 1'b0; e.bus = '0;
        return e;
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic exp_t pop_exp(input int k);
        if (k == 0 && q0.size() > 0) return q0.pop_front();
        if (k == 1 && q1.size() > 0) return q1.pop_front();
        return idle_exp();
    endfunction

    always @(negedge tb_sram_clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                e = pop_exp(k);
                if (e.chk_cs) check($sformatf("cs_n[%0d]", k), 32'(cs_n[k]), 32'(e.cs_n));
                check($sformatf("read_n[%0d]", k),  32'(rd_n[k]), 32'(e.rd_n));
                check($sformatf("write_n[%0d]", k), 32'(wr_n[k]), 32'(e.wr_n));
                check($sformatf("ack[%0d]", k),     32'(ack[k]),  32'(e.ack));
                check($sformatf("err[%0d]", k),     32'(err[k]),  32'(e.err));
                check($sformatf("strobe_excl[%0d]", k), 32'(!rd_n[k] && !wr_n[k]), 32'd0);
                if (e.chk_addr) check($sformatf("addr[%0d]", k), 32'(addr[k]), 32'(e.addr));
                if (e.chk_dat)  check($sformatf("wb_dat[%0d]", k), wb_dat_o[k], e.dat);
                if (e.chk_bus)  check($sformatf("bus[%0d]", k), 32'(bus_obs[k]), 32'(e.bus));
                if (!wr_n[k]) begin
                    wr_low_cnt[k]++;
                    if (cs_n[k] != 4'hF) sram_mem[k][dev_of[k]][addr[k][5:0]] = bus_obs[k];
                end
                if (!rd_n[k]) rd_low_cnt[k]++;
            end
        end
    end

    task automatic step();
        @(posedge tb_sram_clk);
        #1;
    endtask

    // Expected per-cycle behaviour from acceptance (cycle 0) to the ack/err cycle.
    task automatic issue(input int k, input logic [31:0] adr, input logic [3:0] sel,
                         input logic we, input logic [31:0] dat, input int rst_at,
                         output int len, output logic [31:0] exp_dat);
        exp_t e;
        exp_t lst[$];
        int   s, l, dev;
        dev     = int'(adr[22:21]);
        s       = we ? c_WR : rd_cycles(k);
        l       = 1 + s + c_TURN;
        exp_dat = '0;
        lst.push_back(idle_exp());
        if (adr[31:23] != '0) begin
            e = idle_exp(); e.err = 1'b1;
            lst.push_back(e);
        end else if (sel == 4'h0) begin
            e = idle_exp(); e.chk_cs = 1'b0; e.ack = 1'b1; e.chk_dat = !we;
            lst.push_back(e);
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (sel[j]) begin
                    for (int c = 0; c < l; c++) begin
                        e = idle_exp();
                        e.cs_n     = ~(4'b0001 << dev);
                        e.chk_addr = 1'b1;
                        e.addr     = {adr[20:2], 2'(j)};
                        if (c >= 1 && c <= s) begin
                            if (we) e.wr_n = 1'b0;
                            else    e.rd_n = 1'b0;
                        end
                        if (we) begin
                            e.chk_bus = 1'b1; e.bus = dat[8*j +: 8];
                        end else if (c >= 1 && c <= s) begin
                            e.chk_bus = 1'b1; e.bus = ref_mem[k][dev][e.addr[5:0]];
                        end
                        lst.push_back(e);
                    end
                    if (we) ref_mem[k][dev][{adr[5:2], 2'(j)}] = dat[8*j +: 8];
                    else    exp_dat[8*j +: 8] = ref_mem[k][dev][{adr[5:2], 2'(j)}];
                end
            end
            e = idle_exp(); e.chk_cs = 1'b0; e.ack = 1'b1; e.chk_dat = !we; e.dat = exp_dat;
            lst.push_back(e);
        end
        len = lst.size() - 1;

        wb_adr = adr; wb_sel = sel; wb_we = we; wb_dat = dat;
        wb_cyc[k] = 1'b1; wb_stb[k] = 1'b1;
        if (rst_at < 0) begin
            foreach (lst[i]) push_exp(k, lst[i]);
            repeat (len) step();
            step();
            wb_cyc[k] = 1'b0; wb_stb[k] = 1'b0;
        end else begin
            for (int i = 0; i <= rst_at; i++) push_exp(k, lst[i]);
            repeat (rst_at) step();
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            wb_cyc[k] = 1'b0; wb_stb[k] = 1'b0;
            probe_en[k] = 1'b1;
            e = idle_exp();
            e.chk_addr = 1'b1; e.chk_dat = 1'b1; e.chk_bus = 1'b1;
            push_exp(k, e);
            step();
            probe_en[k] = 1'b0;
        end
    endtask

    initial begin
        int          len;
        int          w0, r0;
        logic [31:0] d;
        exp_t        e;

        reset_n = 1'b0;
        wb_adr = '0; wb_sel = '0; wb_we = 1'b0; wb_dat = '0;
        wb_cyc = '0; wb_stb = '0;
        for (int k = 0; k < 2; k++) begin
            probe_en[k] = 1'b0; wr_low_cnt[k] = 0; rd_low_cnt[k] = 0;
            for (int dv = 0; dv < 4; dv++)
                for (int a = 0; a < 64; a++) begin
                    sram_mem[k][dv][a] = 8'h00; ref_mem[k][dv][a] = 8'h00;
                end
            sram_mem[k][3][8]  = 8'h11; ref_mem[k][3][8]  = 8'h11;
            sram_mem[k][3][10] = 8'h33; ref_mem[k][3][10] = 8'h33;
        end

        repeat (3) step();
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e = idle_exp(); e.chk_addr = 1'b1; e.chk_dat = 1'b1;
            push_exp(k, e);
        end
        repeat (2) step();

        // Full-word write, default timing.
        w0 = wr_low_cnt[0];
        issue(0, 32'h0000_0004, 4'hF, 1'b1, 32'hA1B2_C3D4, -1, len, d);
        check("t25_len", 32'(len), 32'd17);
        check("t25_wr_cycles", 32'(wr_low_cnt[0] - w0), 32'd8);
        check("t25_mem4", 32'(sram_mem[0][0][4]), 32'h0000_00D4);
        check("t25_mem5", 32'(sram_mem[0][0][5]), 32'h0000_00C3);
        check("t25_mem6", 32'(sram_mem[0][0][6]), 32'h0000_00B2);
        check("t25_mem7", 32'(sram_mem[0][0][7]), 32'h0000_00A1);
        repeat (2) step();

        // Sparse read from device 3.
        r0 = rd_low_cnt[0];
        issue(0, 32'h0060_0008, 4'b0101, 1'b0, 32'h0, -1, len, d);
        check("t26_len", 32'(len), 32'd9);
        check("t26_model_dat", d, 32'h0033_0011);
        check("t26_rd_cycles", 32'(rd_low_cnt[0] - r0), 32'd4);
        @(negedge tb_sram_clk);
        check("t26_dat_hold", wb_dat_o[0], 32'h0033_0011);
        step();

        // Out-of-range address.
        w0 = wr_low_cnt[0]; r0 = rd_low_cnt[0];
        issue(0, 32'h0080_0000, 4'hF, 1'b0, 32'h0, -1, len, d);
        check("t27_len", 32'(len), 32'd1);
        check("t27_no_strobe", 32'((wr_low_cnt[0] - w0) + (rd_low_cnt[0] - r0)), 32'd0);
        repeat (2) step();

        // Reset during the second ACCESS cycle of a write.
        w0 = wr_low_cnt[0];
        issue(0, 32'h0000_0030, 4'hF, 1'b1, 32'h0102_0304, 3, len, d);
        check("t28_wr_cycles", 32'(wr_low_cnt[0] - w0), 32'd2);
        repeat (20) step();

        // Back-to-back write then read of the same byte, 3-cycle reads.
        r0 = rd_low_cnt[1];
        issue(1, 32'h0000_000C, 4'b0010, 1'b1, 32'h0000_5A00, -1, len, d);
        check("t29_wr_len", 32'(len), 32'd5);
        issue(1, 32'h0000_000C, 4'b0010, 1'b0, 32'h0, -1, len, d);
        check("t29_rd_len", 32'(len), 32'd6);
        check("t29_model_dat", d, 32'h0000_5A00);
        check("t29_rd_cycles", 32'(rd_low_cnt[1] - r0), 32'd3);
        @(negedge tb_sram_clk);
        check("t29_dat", wb_dat_o[1], 32'h0000_5A00);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter SRAM_RD_CYCLES, default 2, giving the number of cycles o_sram_read_n is held low per byte (legal 1..15).
REQ-002 SHALL have parameter SRAM_WR_CYCLES, default 2, giving the number of cycles o_sram_write_n is held low per byte (legal 1..15).
REQ-003 SHALL have parameter SRAM_TURN_CYCLES, default 1, giving the recovery cycles after each strobe (legal 1..15).
REQ-004 SHALL use one clock and a synchronous, active-low reset, with ports as follows.
- i_clk  in  1  system clock; all logic rising-edge
- i_reset_n  in  1  synchronous active-low reset
- i_wb_adr  in  32  Wishbone byte address
- i_wb_sel  in  4  byte selects; bit n = lane n = i_wb_dat[8n+7:8n]
- i_wb_we  in  1  1 = write
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  strobe
- i_wb_dat  in  32  write data
- o_wb_dat  out  32  read data
- o_wb_ack  out  1  single-cycle acknowledge
- o_wb_err  out  1  single-cycle error
- o_sram_cs_n  out  4  chip selects, one per 2Mx8 device
- o_sram_read_n  out  1  output enable
- o_sram_write_n  out  1  write enable
- o_sram_addr  out  21  device byte address
- io_sram_data  inout  8  data bus

Function
REQ-005 SHALL accept a request in IDLE when i_wb_cyc and i_wb_stb are both 1 (acceptance = cycle 0), and SHALL latch adr, sel, we and dat.
REQ-006 SHALL respond to a request with i_wb_adr[31:23] != 0 by asserting o_wb_err in cycle 1 with no SRAM access.
REQ-007 SHALL acknowledge a request with i_wb_sel == 0 in cycle 1 with no SRAM access.
REQ-008 SHALL select the device with o_sram_cs_n[i_wb_adr[22:21]] = 0 and set o_sram_addr = {i_wb_adr[20:2], lane[1:0]}.
REQ-009 SHALL access only the selected lanes, in ascending lane order.
REQ-010 SHALL run each lane through three states.
- SETUP: 1 cycle; cs/addr valid; strobes high.
- ACCESS: SRAM_RD_CYCLES or SRAM_WR_CYCLES cycles; the matching strobe low.
- RECOVER: SRAM_TURN_CYCLES cycles; strobes high; cs/addr held.
REQ-011 SHALL drive io_sram_data for a write lane during SETUP, ACCESS and RECOVER, and SHALL tri-state it at all other times.
REQ-012 SHALL tri-state io_sram_data whenever o_sram_read_n is 0; the data bus and read_n SHALL never both be driven.
REQ-013 SHALL sample io_sram_data on the clock edge that ends the last ACCESS cycle of a read lane and store it into lane n of o_wb_dat.
REQ-014 SHALL return 0 in unselected read lanes.
REQ-015 SHALL assert o_wb_ack for exactly one cycle in cycle 1 + N*(1 + strobe cycles + SRAM_TURN_CYCLES), where N is the number of selected lanes.
REQ-016 SHALL keep o_wb_dat stable from the ack cycle until the next acceptance.
REQ-017 SHALL NOT accept a new request in the ack or err cycle; the earliest next acceptance is the following cycle.
REQ-018 SHALL, if i_wb_cyc drops mid-transaction, finish the current lane through RECOVER, then return to IDLE with no ack.
REQ-019 SHALL hold o_sram_cs_n at 4'hF in IDLE.
REQ-020 SHALL never assert o_sram_read_n and o_sram_write_n low at the same time.

Reset
REQ-021 SHALL, when i_reset_n = 0 at a clock edge (including mid-access), set the following on the next cycle:
- state IDLE;
- o_sram_cs_n = 4'hF, o_sram_read_n = 1, o_sram_write_n = 1;
- o_sram_addr = 0, io_sram_data = Z;
- o_wb_ack = 0, o_wb_err = 0, o_wb_dat = 0.
REQ-022 SHALL discard any in-flight transaction on reset, with no ack.

Structure
REQ-023 SHALL place in package sram_ctrl_pkg: the state encoding (IDLE, SETUP, ACCESS, RECOVER, ACK, ERR), the default timing constants, and the lane/chip-select width constants.
REQ-024 SHALL implement the ACCESS and RECOVER cycle counting in one sub-module, sram_ctrl_timer: a 4-bit loadable down-counter with a done flag.

Verification
REQ-025 SHALL cover: write adr 0x00000004, sel 4'hF, dat 0xA1B2C3D4, defaults -> four write strobes to addr 4,5,6,7 with data D4,C3,B2,A1, cs_n = 4'hE, ack in cycle 17.
REQ-026 SHALL cover: read adr 0x00600008, sel 4'b0101, model returns 0x11 then 0x33 -> cs_n = 4'h7, addr 8 then 10, ack in cycle 9, o_wb_dat = 0x00330011.
REQ-027 SHALL cover: adr 0x00800000 -> o_wb_err in cycle 1, cs_n stays 4'hF, no strobe.
REQ-028 SHALL cover: i_reset_n = 0 during the 2nd ACCESS cycle of a write -> next cycle strobes high, cs_n = 4'hF, bus Z, no ack.
REQ-029 SHALL cover: back-to-back write then read to the same address, SRAM_RD_CYCLES = 3 -> read data equals written byte, read_n low for 3 cycles, no bus contention at any cycle.
